// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// controller states and the byte-count decode.
package lsu_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP, FAULT} state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 4'd1;
      SIZE_H:  size_bytes = 4'd2;
      SIZE_W:  size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte lane logic: extracts and extends a load field from a
// doubleword, and merges store bytes into a previously read doubleword.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [2:0]        off,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ldata,
  output logic [DATA_W-1:0] mdata
);

  logic [5:0]        bit_off;
  logic [3:0]        last;
  logic [DATA_W-1:0] field;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] mask;

  assign bit_off = {off, 3'b000};
  assign field   = rdata >> bit_off;
  assign wshift  = wdata << bit_off;
  // One past the highest byte lane the access touches.
  assign last    = {1'b0, off} + size_bytes(size);

  always_comb begin
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) >= {1'b0, off}) && (4'(i) < last)) mask[8*i +: 8] = 8'hFF;
    end
  end

  always_comb begin
    ldata = field;
    case (size)
      SIZE_B:  ldata = {{56{sign & field[7]}},  field[7:0]};
      SIZE_H:  ldata = {{48{sign & field[15]}}, field[15:0]};
      SIZE_W:  ldata = {{32{sign & field[31]}}, field[31:0]};
      default: ldata = field;
    endcase
  end

  assign mdata = (rdata & ~mask) | (wshift & mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a 64-bit word-indexed DataMemory without byte
// enables: sub-dword stores run as read-modify-write, faults answer at once.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [63:0] ReqAddr,
  input  logic [63:0] ReqWData,
  output logic        RespValid,
  output logic [63:0] RespData,
  output logic        RespFault,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [63:0] MemReadData
);

  state_t      state, state_nx;
  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        req_fault;

  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [2:0]  req_off;
  logic [63:0] req_wdata;
  logic [63:0] rdata_p1;
  logic [63:0] mem_idx;
  logic [63:0] ldata;
  logic [63:0] mdata;

  always_comb begin
    case (ReqSize)
      SIZE_B:  misaligned = 1'b0;
      SIZE_H:  misaligned = ReqAddr[0];
      SIZE_W:  misaligned = |ReqAddr[1:0];
      default: misaligned = |ReqAddr[2:0];
    endcase
  end

  assign out_of_range = {3'b000, ReqAddr[63:3]} >= 64'(DEPTH);
  assign req_fault    = misaligned | out_of_range;
  assign accept       = ReqValid & (state == IDLE);

  lsu_align u_align (
    .size  (req_size),
    .sign  (req_signed),
    .off   (req_off),
    .rdata (rdata_p1),
    .wdata (req_wdata),
    .ldata (ldata),
    .mdata (mdata)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      req_write  <= 1'b0;
      req_size   <= 2'b00;
      req_signed <= 1'b0;
      req_off    <= 3'b000;
      req_wdata  <= '0;
      rdata_p1   <= '0;
      mem_idx    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_write  <= ReqWrite;
        req_size   <= ReqSize;
        req_signed <= ReqSigned;
        req_off    <= ReqAddr[2:0];
        req_wdata  <= ReqWData;
        // A faulting request never reaches memory, so the address bus keeps its last value.
        if (!req_fault) mem_idx <= {3'b000, ReqAddr[63:3]};
      end
      if (state == RD_WAIT) rdata_p1 <= MemReadData;
    end
  end

  always_comb begin
    state_nx     = state;
    ReqReady     = 1'b0;
    RespValid    = 1'b0;
    RespFault    = 1'b0;
    RespData     = '0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemWriteData = '0;
    MemAddress   = mem_idx;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          if (req_fault)                         state_nx = FAULT;
          else if (ReqWrite && ReqSize == SIZE_D) state_nx = WR;
          else                                    state_nx = RD;
        end
      end
      RD: begin
        MemRead  = 1'b1;
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        MemRead  = 1'b1;
        state_nx = req_write ? WR : RESP;
      end
      WR: begin
        MemWrite     = 1'b1;
        MemWriteData = mdata;
        state_nx     = RESP;
      end
      RESP: begin
        RespValid = 1'b1;
        if (!req_write) RespData = ldata;
        state_nx  = IDLE;
      end
      FAULT: begin
        RespValid = 1'b1;
        RespFault = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 64 x 64-bit DataMemory.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int PERIOD = 50;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [63:0] ReqAddr = '0;
  logic [63:0] ReqWData = '0;
  logic        RespValid;
  logic [63:0] RespData;
  logic        RespFault;
  logic [63:0] MemAddress;
  logic [63:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] MemReadData = '0;

  logic [63:0] mem [64];

  typedef struct {
    string       tag;
    logic [63:0] data;
    logic        fault;
    int          lat;
    int          nrd;
    int          nwr;
    longint      t0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   nrd = 0;
  int   nwr = 0;
  bit   both_high = 1'b0;

  load_store_unit #(.DEPTH(64)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RespValid    (RespValid),
    .RespData     (RespData),
    .RespFault    (RespFault),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemReadData  (MemReadData)
  );

  initial forever #(PERIOD/2) Clock = ~Clock;

  always @(posedge Clock)
    if (MemRead && MemAddress < 64) MemReadData <= mem[MemAddress[5:0]];

  always @(negedge Clock)
    if (MemWrite && MemAddress < 64) mem[MemAddress[5:0]] = MemWriteData;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Response monitor and strobe accounting
  always @(negedge Clock) begin
    exp_t e;
    if (MemRead && MemWrite) both_high = 1'b1;
    if (Reset) begin
      nrd = 0;
      nwr = 0;
    end else begin
      nrd += int'(MemRead);
      nwr += int'(MemWrite);
      if (RespValid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check({e.tag, "_data"},  RespData, e.data);
          check({e.tag, "_fault"}, 64'(RespFault), 64'(e.fault));
          check({e.tag, "_lat"},   64'(($time - e.t0) / PERIOD), 64'(e.lat));
          check({e.tag, "_nrd"},   64'(nrd), 64'(e.nrd));
          check({e.tag, "_nwr"},   64'(nwr), 64'(e.nwr));
        end
        nrd = 0;
        nwr = 0;
      end
    end
  end

  task automatic send(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] edata,
                      input logic efault, input int elat, input int erd, input int ewr,
                      input bit track, input bit hold);
    exp_t e;
    int guard = 0;
    @(negedge Clock);
    while (!ReqReady && guard < 20) begin
      @(negedge Clock);
      guard++;
    end
    if (!ReqReady) begin
      check({tag, "_ready_timeout"}, 64'd0, 64'd1);
      ReqValid = 1'b0;
      return;
    end
    ReqValid  = 1'b1;
    ReqWrite  = wr;
    ReqSize   = sz;
    ReqSigned = sg;
    ReqAddr   = addr;
    ReqWData  = wd;
    if (track) begin
      e.tag = tag; e.data = edata; e.fault = efault; e.lat = elat;
      e.nrd = erd; e.nwr = ewr; e.t0 = $time;
      sb.push_back(e);
    end
    @(posedge Clock);
    @(negedge Clock);
    if (!hold) ReqValid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int guard = 0;
    while ((sb.size() != 0 || !ReqReady) && guard < 40) begin
      @(negedge Clock);
      guard++;
    end
    if (sb.size() != 0) check({tag, "_drain_timeout"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[1] = 64'h0000_0000_F000_0000;
    mem[2] = 64'h8877_6655_4433_2211;
    mem[3] = 64'h0123_4567_89AB_CDEF;
    mem[4] = 64'h1111_2222_3333_4444;

    #2 Reset = 1'b1;
    #1;
    check("rst_ready", 64'(ReqReady), 64'd1);
    check("rst_respvalid", 64'(RespValid), 64'd0);
    check("rst_respdata", RespData, 64'd0);
    check("rst_respfault", 64'(RespFault), 64'd0);
    check("rst_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    check("rst_memaddr", MemAddress, 64'd0);
    check("rst_memwdata", MemWriteData, 64'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;

    // Loads: extraction and extension
    send("ld_b_13_s", 1'b0, SIZE_B, 1'b1, 64'h13, '0, 64'h44, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_w_08_s", 1'b0, SIZE_W, 1'b1, 64'h08, '0, 64'hFFFF_FFFF_F000_0000, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_w_08_u", 1'b0, SIZE_W, 1'b0, 64'h08, '0, 64'h0000_0000_F000_0000, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_w_0c_s", 1'b0, SIZE_W, 1'b1, 64'h0C, '0, 64'h0, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_b_17_s", 1'b0, SIZE_B, 1'b1, 64'h17, '0, 64'hFFFF_FFFF_FFFF_FF88, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_b_17_u", 1'b0, SIZE_B, 1'b0, 64'h17, '0, 64'h88, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_h_16_s", 1'b0, SIZE_H, 1'b1, 64'h16, '0, 64'hFFFF_FFFF_FFFF_8877, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    send("ld_d_10_s", 1'b0, SIZE_D, 1'b1, 64'h10, '0, 64'h8877_6655_4433_2211, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    wait_done("loads");

    // Sub-dword stores: read-modify-write
    send("st_h_06", 1'b1, SIZE_H, 1'b0, 64'h06, 64'hBEEF, 64'h0, 1'b0, 4, 2, 1, 1'b1, 1'b0);
    send("st_b_21", 1'b1, SIZE_B, 1'b0, 64'h21, 64'hFFFF_FFFF_FFFF_FFA5, 64'h0, 1'b0, 4, 2, 1, 1'b1, 1'b0);
    wait_done("stores");
    check("mem0_after_half", mem[0], 64'hBEEF_0000_0000_0000);
    check("mem4_after_byte", mem[4], 64'h1111_2222_3333_A544);
    send("ld_h_22_s", 1'b0, SIZE_H, 1'b1, 64'h22, '0, 64'h3333, 1'b0, 3, 2, 0, 1'b1, 1'b0);

    // Faults: misaligned and out of range
    send("flt_w_02",  1'b0, SIZE_W, 1'b0, 64'h02,  '0, 64'h0, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    send("flt_d_200", 1'b0, SIZE_D, 1'b0, 64'h200, '0, 64'h0, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    send("flt_h_1ff", 1'b1, SIZE_H, 1'b0, 64'h1FF, 64'h1234, 64'h0, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    send("st_d_1f8",  1'b1, SIZE_D, 1'b0, 64'h1F8, 64'hCAFE_F00D_0000_0001, 64'h0, 1'b0, 2, 0, 1, 1'b1, 1'b0);
    send("flt_d_st_200", 1'b1, SIZE_D, 1'b0, 64'h200, 64'hDEAD, 64'h0, 1'b1, 1, 0, 0, 1'b1, 1'b0);
    wait_done("faults");
    check("mem63_dword", mem[63], 64'hCAFE_F00D_0000_0001);
    check("memaddr_held", MemAddress, 64'd63);

    // Reset while a sub-dword store is reading
    send("abort_st", 1'b1, SIZE_B, 1'b0, 64'h18, 64'h55, 64'h0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    @(posedge Clock);
    #5;
    check("abort_in_rdwait", 64'(MemRead), 64'd1);
    Reset = 1'b1;
    #1;
    check("abort_strobes", {62'd0, MemRead, MemWrite}, 64'd0);
    check("abort_respvalid", 64'(RespValid), 64'd0);
    check("abort_ready", 64'(ReqReady), 64'd1);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    check("abort_mem_unchanged", mem[3], 64'h0123_4567_89AB_CDEF);
    send("post_abort_ld", 1'b0, SIZE_D, 1'b0, 64'h18, '0, 64'h0123_4567_89AB_CDEF, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    wait_done("abort");

    // Back-to-back dword stores with ReqValid held, then read back
    send("b2b_st0", 1'b1, SIZE_D, 1'b0, 64'h00, 64'hA0A0_0000_1111_0000, 64'h0, 1'b0, 2, 0, 1, 1'b1, 1'b1);
    send("b2b_st1", 1'b1, SIZE_D, 1'b0, 64'h08, 64'hB1B1_0000_2222_0001, 64'h0, 1'b0, 2, 0, 1, 1'b1, 1'b1);
    send("b2b_st2", 1'b1, SIZE_D, 1'b0, 64'h10, 64'hC2C2_0000_3333_0002, 64'h0, 1'b0, 2, 0, 1, 1'b1, 1'b0);
    send("b2b_ld0", 1'b0, SIZE_D, 1'b0, 64'h00, '0, 64'hA0A0_0000_1111_0000, 1'b0, 3, 2, 0, 1'b1, 1'b1);
    send("b2b_ld1", 1'b0, SIZE_D, 1'b0, 64'h08, '0, 64'hB1B1_0000_2222_0001, 1'b0, 3, 2, 0, 1'b1, 1'b1);
    send("b2b_ld2", 1'b0, SIZE_D, 1'b0, 64'h10, '0, 64'hC2C2_0000_3333_0002, 1'b0, 3, 2, 0, 1'b1, 1'b0);
    wait_done("b2b");

    repeat (4) @(negedge Clock);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("strobes_exclusive", 64'(both_high), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
